// File: rtl/ins_fetch_mem.sv
// rtl/ins_fetch_mem.sv - instruction memory with multi-lane fetch, strobed write port and clear engine
module ins_fetch_mem #(
    parameter int    MEM_DEPTH   = 64,
    parameter int    DATA_W      = 32,
    parameter int    ADDR_W      = 32,
    parameter int    FETCH_PORTS = 2,
    parameter string INIT_FILE   = "instructions.hex"
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fetch_valid,
    output logic                          fetch_ready,
    input  logic [ADDR_W-1:0]             fetch_addr,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_W*FETCH_PORTS-1:0] resp_data,
    output logic [FETCH_PORTS-1:0]        resp_fault,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [DATA_W/8-1:0]           wr_strb,
    input  logic                          clr_start,
    output logic                          clr_busy
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(MEM_DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MEM_DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } clr_state_e;

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    clr_state_e                    state_q, state_d;
    logic [IDX_W-1:0]              cnt_q, cnt_d;
    logic                          clr_busy_q, clr_busy_d;
    logic                          resp_valid_q, resp_valid_d;
    logic [DATA_W*FETCH_PORTS-1:0] resp_data_q, resp_data_d;
    logic [FETCH_PORTS-1:0]        resp_fault_q, resp_fault_d;

    logic                          fetch_ready_c;
    logic                          fetch_fire;
    logic                          fetch_misaligned;
    logic                          wr_fire;
    logic [ADDR_W-1:0]             wr_idx;
    logic [DATA_W-1:0]             wr_merged;
    logic [ADDR_W-1:0]             lane_addr;
    logic [ADDR_W-1:0]             lane_idx;
    logic [DATA_W*FETCH_PORTS-1:0] lane_data;
    logic [FETCH_PORTS-1:0]        lane_fault;

    // Merged write word is computed up front so a same-cycle fetch can see it.
    always_comb begin
        wr_idx    = wr_addr >> OFF_W;
        wr_fire   = wr_en && !clr_busy_q && ((wr_addr & OFF_MASK) == '0) && (wr_idx < DEPTH_A);
        wr_merged = mem_q[wr_idx[IDX_W-1:0]];
        for (int b = 0; b < BYTES; b++) begin
            if (wr_strb[b]) begin
                wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    always_comb begin
        fetch_misaligned = (fetch_addr & OFF_MASK) != '0;
        lane_addr        = '0;
        lane_idx         = '0;
        lane_data        = '0;
        lane_fault       = '0;
        for (int i = 0; i < FETCH_PORTS; i++) begin
            lane_addr = fetch_addr + ADDR_W'(i * BYTES);
            lane_idx  = lane_addr >> OFF_W;
            if (fetch_misaligned || (lane_idx >= DEPTH_A)) begin
                lane_fault[i] = 1'b1;
            end else if (wr_fire && (wr_idx == lane_idx)) begin
                lane_data[i*DATA_W +: DATA_W] = wr_merged;
            end else begin
                lane_data[i*DATA_W +: DATA_W] = mem_q[lane_idx[IDX_W-1:0]];
            end
        end
    end

    always_comb begin
        fetch_ready_c = !clr_busy_q && (!resp_valid_q || resp_ready);
        fetch_fire    = fetch_valid && fetch_ready_c;

        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_fault_d = resp_fault_q;
        if (fetch_fire) begin
            resp_valid_d = 1'b1;
            resp_data_d  = lane_data;
            resp_fault_d = lane_fault;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end

        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_busy_d = clr_busy_q;
        case (state_q)
            S_IDLE: begin
                if (clr_start) begin
                    state_d    = S_CLEAR;
                    cnt_d      = '0;
                    clr_busy_d = 1'b1;
                end
            end
            S_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    clr_busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d    = S_IDLE;
                cnt_d      = '0;
                clr_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            clr_busy_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_fault_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            clr_busy_q   <= clr_busy_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // Array has no reset; a reset mid-clear leaves already-zeroed words as they are.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_fire) begin
            mem_q[wr_idx[IDX_W-1:0]] <= wr_merged;
        end
    end

    assign fetch_ready = fetch_ready_c;
    assign resp_valid  = resp_valid_q;
    assign resp_data   = resp_data_q;
    assign resp_fault  = resp_fault_q;
    assign clr_busy    = clr_busy_q;

endmodule
